// File: rtl/qptr_pkg.sv
// Shared types and pointer helpers for the circular-queue allocator.
// Pointers carry a wrap flag so full and empty are distinguishable.
package qptr_pkg;

    localparam int DEPTH = 32;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic             flag;
        logic [PTR_W-1:0] idx;
    } qptr_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } qstate_t;

    // count never exceeds DEPTH, so idx + count < 2*DEPTH
    function automatic qptr_t qptr_add(qptr_t p, logic [PTR_W:0] count);
        logic [PTR_W:0] s;
        qptr_t          r;
        s      = {1'b0, p.idx} + count;
        r.flag = p.flag ^ s[PTR_W];
        r.idx  = s[PTR_W-1:0];
        return r;
    endfunction

    function automatic logic [PTR_W:0] qptr_dist(qptr_t e, qptr_t d);
        logic [PTR_W:0] s;
        if (e.flag == d.flag)
            s = {1'b0, e.idx} - {1'b0, d.idx};
        else
            s = (PTR_W+1)'(DEPTH) + {1'b0, e.idx} - {1'b0, d.idx};
        return s;
    endfunction

endpackage

// File: rtl/qptr_grant_prefix.sv
// In-order prefix grant: requester i wins only if every valid older one
// wins and the running entry sum still fits in the available capacity.
module qptr_grant_prefix #(
    parameter int NUM_REQ = 3,
    parameter int REQ_W   = 5,
    parameter int CAP_W   = 6,
    parameter int SUM_W   = 8
) (
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*REQ_W-1:0] req_num,
    input  logic [CAP_W-1:0]         cap,
    output logic [NUM_REQ-1:0]       grant,
    output logic [SUM_W-1:0]         total
);

    logic [SUM_W-1:0] acc;
    logic [SUM_W-1:0] nxt;
    logic             ok;

    always_comb begin
        acc   = '0;
        nxt   = '0;
        ok    = en;
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            nxt = acc + SUM_W'(req_num[i*REQ_W +: REQ_W]);
            if (req_valid[i]) begin
                if (ok && (nxt <= SUM_W'(cap))) begin
                    grant[i] = 1'b1;
                    acc      = nxt;
                end else begin
                    ok = 1'b0;
                end
            end
        end
        total = acc;
    end

endmodule

// File: rtl/qptr_alloc_ctrl.sv
// Enqueue/dequeue pointer owner for a circular queue with multi-port
// in-order allocation, flush recovery hold and sticky underflow flag.
module qptr_alloc_ctrl
    import qptr_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int REQ_W      = 5,
    parameter int DEQ_W      = 4,
    parameter int FLUSH_HOLD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*REQ_W-1:0] req_num,
    output logic [NUM_REQ-1:0]       grant,
    output logic [PTR_W:0]           enq_ptr,
    output logic [PTR_W:0]           deq_ptr,
    input  logic [DEQ_W-1:0]         deq_num,
    input  logic                     flush,
    output logic [PTR_W:0]           occupancy,
    output logic [PTR_W:0]           free_cnt,
    output logic                     full,
    output logic                     empty,
    output logic                     busy,
    output logic                     err
);

    localparam int RS_W  = REQ_W + $clog2(NUM_REQ + 1);
    localparam int SUM_W = ((PTR_W + 1 > RS_W) ? PTR_W + 1 : RS_W) + 1;
    localparam int CW    = (DEQ_W > PTR_W + 1) ? DEQ_W : PTR_W + 1;
    localparam int HC_W  = (FLUSH_HOLD > 2) ? $clog2(FLUSH_HOLD) : 1;
    localparam logic [HC_W-1:0] HC_LOAD =
        HC_W'((FLUSH_HOLD > 0) ? FLUSH_HOLD - 1 : 0);

    qptr_t            enq_q;
    qptr_t            deq_q;
    qstate_t          state;
    logic [HC_W-1:0]  hold_cnt;
    logic [SUM_W-1:0] total;
    logic [PTR_W:0]   gcnt;
    logic [PTR_W:0]   eff;
    logic             under;

    assign occupancy = qptr_dist(enq_q, deq_q);
    assign free_cnt  = (PTR_W+1)'(DEPTH) - occupancy;
    assign full      = occupancy == (PTR_W+1)'(DEPTH);
    assign empty     = occupancy == '0;
    assign busy      = state == HOLD;
    assign enq_ptr   = enq_q;
    assign deq_ptr   = deq_q;

    qptr_grant_prefix #(
        .NUM_REQ (NUM_REQ),
        .REQ_W   (REQ_W),
        .CAP_W   (PTR_W + 1),
        .SUM_W   (SUM_W)
    ) u_prefix (
        .en        (state == RUN && !flush),
        .req_valid (req_valid),
        .req_num   (req_num),
        .cap       (free_cnt),
        .grant     (grant),
        .total     (total)
    );

    // granted total is bounded by free_cnt, so this narrowing is lossless
    assign gcnt  = (PTR_W+1)'(total);
    assign under = CW'(deq_num) > CW'(occupancy);
    assign eff   = under ? occupancy : (PTR_W+1)'(deq_num);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enq_q <= '0;
            deq_q <= '0;
            err   <= 1'b0;
        end else begin
            deq_q <= qptr_add(deq_q, eff);
            if (flush)
                enq_q <= qptr_add(deq_q, eff);
            else
                enq_q <= qptr_add(enq_q, gcnt);
            if (under)
                err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            hold_cnt <= '0;
        end else if (flush && FLUSH_HOLD != 0) begin
            state    <= HOLD;
            hold_cnt <= HC_LOAD;
        end else if (state == HOLD) begin
            if (hold_cnt == '0)
                state <= RUN;
            else
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_qptr_alloc_ctrl.sv
// Directed-vector bench for qptr_alloc_ctrl with hand-computed expectations.
module tb_qptr_alloc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [14:0] req_num;
    logic [2:0]  grant;
    logic [5:0]  enq_ptr;
    logic [5:0]  deq_ptr;
    logic [3:0]  deq_num;
    logic        flush;
    logic [5:0]  occupancy;
    logic [5:0]  free_cnt;
    logic        full;
    logic        empty;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qptr_alloc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_num   (req_num),
        .grant     (grant),
        .enq_ptr   (enq_ptr),
        .deq_ptr   (deq_ptr),
        .deq_num   (deq_num),
        .flush     (flush),
        .occupancy (occupancy),
        .free_cnt  (free_cnt),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .err       (err)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input int n2, input int n1,
                         input int n0, input int dq, input logic fl);
        req_valid = v;
        req_num   = {5'(n2), 5'(n1), 5'(n0)};
        deq_num   = 4'(dq);
        flush     = fl;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(3'b000, 0, 0, 0, 0, 1'b0);
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_free", free_cnt, 32);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_enq", enq_ptr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // three requests totalling 12
        drive(3'b111, 5, 4, 3, 0, 1'b0);
        chk("g3_grant", grant, 3'b111);
        tick();
        drive(3'b000, 0, 0, 0, 0, 1'b0);
        chk("g3_enq", enq_ptr, 12);
        chk("g3_occ", occupancy, 12);
        chk("g3_free", free_cnt, 20);

        // enq -> 30, deq -> 10 in one edge
        drive(3'b001, 0, 0, 18, 10, 1'b0);
        chk("pre_grant", grant, 3'b001);
        tick();
        chk("pre_enq", enq_ptr, 30);
        chk("pre_deq", deq_ptr, 10);
        chk("pre_occ", occupancy, 20);
        drive(3'b000, 0, 0, 0, 10, 1'b0);
        tick();
        chk("wrap_deq", deq_ptr, 20);
        drive(3'b001, 0, 0, 10, 0, 1'b0);
        chk("wrap_grant", grant, 3'b001);
        tick();
        drive(3'b000, 0, 0, 0, 0, 1'b0);
        chk("wrap_enq", enq_ptr, 6'b1_01000);
        chk("wrap_occ", occupancy, 20);
        chk("wrap_free", free_cnt, 12);

        // prefix blocking, then transparency of an invalid requester
        drive(3'b111, 0, 5, 10, 0, 1'b0);
        chk("pfx_block", grant, 3'b001);
        drive(3'b101, 0, 5, 10, 0, 1'b0);
        chk("pfx_skip", grant, 3'b101);

        // fill to full, then zero-size and one-entry requests
        drive(3'b001, 0, 0, 12, 0, 1'b0);
        chk("fill_grant", grant, 3'b001);
        tick();
        drive(3'b001, 0, 0, 0, 0, 1'b0);
        chk("full_flag", full, 1);
        chk("full_free", free_cnt, 0);
        chk("full_zero_req", grant, 3'b001);
        drive(3'b001, 0, 0, 1, 0, 1'b0);
        chk("full_one_req", grant, 3'b000);

        // drain 32 entries
        drive(3'b000, 0, 0, 0, 15, 1'b0);
        tick();
        chk("drain1_occ", occupancy, 17);
        tick();
        chk("drain2_occ", occupancy, 2);
        drive(3'b000, 0, 0, 0, 2, 1'b0);
        tick();
        drive(3'b000, 0, 0, 0, 0, 1'b0);
        chk("drain_empty", empty, 1);
        chk("drain_free", free_cnt, 32);
        chk("drain_deq", deq_ptr, 6'b1_10100);

        // 3x31 must not wrap into a fit
        drive(3'b111, 31, 31, 31, 0, 1'b0);
        chk("nowrap_grant", grant, 3'b001);

        // occupancy 20, then flush with a dequeue of 3
        drive(3'b001, 0, 0, 20, 0, 1'b0);
        tick();
        chk("fl_occ", occupancy, 20);
        chk("fl_enq_pre", enq_ptr, 6'b0_01000);
        drive(3'b001, 0, 0, 1, 3, 1'b1);
        chk("fl_grant0", grant, 3'b000);
        tick();
        drive(3'b001, 0, 0, 1, 0, 1'b0);
        chk("fl_empty", empty, 1);
        chk("fl_enq", enq_ptr, 55);
        chk("fl_deq", deq_ptr, 55);
        chk("fl_busy1", busy, 1);
        chk("fl_grant1", grant, 3'b000);
        tick();
        chk("fl_busy2", busy, 1);
        chk("fl_grant2", grant, 3'b000);
        tick();
        chk("fl_busy3", busy, 0);
        drive(3'b001, 0, 0, 2, 0, 1'b0);
        chk("fl_grant3", grant, 3'b001);
        tick();
        drive(3'b000, 0, 0, 0, 5, 1'b0);
        chk("uf_occ", occupancy, 2);
        chk("uf_err_pre", err, 0);
        tick();
        drive(3'b001, 0, 0, 3, 0, 1'b0);
        chk("uf_deq", deq_ptr, 57);
        chk("uf_empty", empty, 1);
        chk("uf_err", err, 1);
        tick();
        drive(3'b000, 0, 0, 0, 0, 1'b0);
        chk("uf_traffic_occ", occupancy, 3);
        chk("uf_err_sticky", err, 1);
        tick();
        chk("uf_err_sticky2", err, 1);

        rst_n = 1'b0;
        #1;
        chk("rst2_err", err, 0);
        chk("rst2_occ", occupancy, 0);
        chk("rst2_enq", enq_ptr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

endmodule
